// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared types and constants for the ADC sample scheduler.
//   state_t     - scheduler FSM states
//   ADC_W       - conversion result width
//   CH_W        - ADC channel select width
//   TIMEOUT_DEF - default WAIT abort limit in clk cycles
package adc_sched_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
    localparam int ADC_W       = 12;
    localparam int CH_W        = 3;
    localparam int TIMEOUT_DEF = 1024;
endpackage

// File: rtl/adc_rr_arbiter.sv
// adc_rr_arbiter: 2-way round-robin arbiter with a last-served register.
//   clk, rst - clock, asynchronous active-high reset
//   req      - request vector {req1, req0}
//   update   - load served into the last-served register
//   served   - index of the requester just served
//   winner   - combinational index of the requester to grant
module adc_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       winner
);
    logic last;

    // On a tie the requester that was not served last wins; reset favours 0.
    always_comb winner = (req == 2'b11) ? ~last : req[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= 1'b1;
        else if (update) last <= served;
    end
endmodule

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: arbitrates two requesters onto one ADC read engine.
//   clk, rst               - clock, asynchronous active-high reset
//   req0/ch0, req1/ch1     - level requests with their channel selects
//   gnt                    - one-hot grant pulse
//   rsp_valid/data/err     - one-hot response pulse, result, timeout flag
//   conv_start/conv_ch     - engine start pulse and channel
//   conv_done/conv_data    - engine completion pulse and sample
//   busy                   - high whenever the FSM is not IDLE
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [CH_W-1:0]  ch0,
    input  logic             req1,
    input  logic [CH_W-1:0]  ch1,
    output logic [1:0]       gnt,
    output logic [1:0]       rsp_valid,
    output logic [ADC_W-1:0] rsp_data,
    output logic             rsp_err,
    output logic             conv_start,
    output logic [CH_W-1:0]  conv_ch,
    input  logic             conv_done,
    input  logic [ADC_W-1:0] conv_data,
    output logic             busy
);
    localparam logic [10:0] TMAX = 11'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [10:0] timer;
    logic        owner, winner, accept, finish;

    adc_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .update (state == RESP),
        .served (owner),
        .winner (winner)
    );

    always_comb begin
        accept  = (state == IDLE) && (req0 || req1);
        // conv_done takes priority over a coincident timeout
        finish  = (state == WAIT) && (conv_done || timer == TMAX);
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? START : IDLE;
            START:   state_n = WAIT;
            WAIT:    state_n = finish ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            conv_start <= 1'b0;
            conv_ch    <= '0;
            busy       <= 1'b0;
            timer      <= '0;
            owner      <= 1'b0;
        end else begin
            busy       <= state_n != IDLE;
            gnt        <= accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
            conv_start <= state == START;
            rsp_valid  <= finish ? (owner ? 2'b10 : 2'b01) : 2'b00;
            timer      <= (state == START) ? '0 :
                          (state == WAIT && timer != TMAX) ? timer + 11'd1 : timer;
            if (accept) begin
                conv_ch <= winner ? ch1 : ch0;
                owner   <= winner;
            end
            if (finish) begin
                rsp_data <= conv_done ? conv_data : '0;
                rsp_err  <= ~conv_done;
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: randomized self-checking bench against a transaction-level model.
module tb_adc_sample_scheduler;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst, req0, req1, conv_done;
    logic [2:0]  ch0, ch1, conv_ch;
    logic [11:0] conv_data, rsp_data;
    logic [1:0]  gnt, rsp_valid;
    logic        rsp_err, conv_start, busy;

    int   errors = 0;
    int   checks = 0;
    logic last = 1'b1;
    logic r0 = 1'b0;
    logic r1 = 1'b0;

    adc_sample_scheduler #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .ch0        (ch0),
        .req1       (req1),
        .ch1        (ch1),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .conv_start (conv_start),
        .conv_ch    (conv_ch),
        .conv_done  (conv_done),
        .conv_data  (conv_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_conv_start"}, conv_start, 0);
        check({tag, "_conv_ch"}, conv_ch, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One full transaction, entered and left at a negedge with the DUT in IDLE.
    // n0/n1 raise new requests (held ones persist), c0/c1 are their channels,
    // d is the conv_done delay in cycles after conv_start (>= T means never).
    task automatic txn(input logic n0, input logic n1, input logic [2:0] c0, input logic [2:0] c1,
                       input int d, input logic [11:0] data, input logic spur);
        logic       w;
        logic [2:0] wch;
        int         kend;
        if (!n0 && !n1 && !r0 && !r1) n0 = 1'b1;
        if (n0 && !r0) ch0 = c0;
        if (n1 && !r1) ch1 = c1;
        r0 = r0 | n0;
        r1 = r1 | n1;
        req0 = r0;
        req1 = r1;
        w    = (r0 && r1) ? ~last : r1;
        wch  = w ? ch1 : ch0;
        kend = (d < T - 1) ? d : T - 1;
        @(negedge clk);
        check("gnt", gnt, w ? 2 : 1);
        check("conv_ch", conv_ch, wch);
        check("busy_start", busy, 1);
        check("start_early", conv_start, 0);
        if (w) r1 = 1'b0; else r0 = 1'b0;
        req0 = r0;
        req1 = r1;
        conv_done = spur;
        conv_data = 12'($urandom);
        @(negedge clk);
        check("conv_start", conv_start, 1);
        check("gnt_pulse", gnt, 0);
        check("rsp_in_start", rsp_valid, 0);
        for (int k = 0; k <= kend; k++) begin
            if (k > 0) begin
                check("start_pulse", conv_start, 0);
                check("rsp_early", rsp_valid, 0);
                check("busy_wait", busy, 1);
            end
            conv_done = (k == d);
            conv_data = (k == d) ? data : 12'($urandom);
            @(negedge clk);
        end
        conv_done = spur;
        conv_data = 12'($urandom);
        check("rsp_valid", rsp_valid, w ? 2 : 1);
        check("rsp_data", rsp_data, (d < T) ? data : 12'h000);
        check("rsp_err", rsp_err, (d < T) ? 0 : 1);
        check("conv_ch_hold", conv_ch, wch);
        last = w;
        @(negedge clk);
        conv_done = 1'b0;
        check("busy_idle", busy, 0);
        check("rsp_pulse", rsp_valid, 0);
    endtask

    task automatic idle_spur();
        conv_done = 1'b1;
        conv_data = 12'($urandom);
        @(negedge clk);
        conv_done = 1'b0;
        check("spur_gnt", gnt, 0);
        check("spur_rsp", rsp_valid, 0);
        check("spur_busy", busy, 0);
        @(negedge clk);
        check("spur_rsp2", rsp_valid, 0);
        check("spur_busy2", busy, 0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; ch0 = '0; ch1 = '0;
        conv_done = 1'b0; conv_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");
        idle_spur();

        txn(1'b1, 1'b0, 3'd3, 3'd0, 2, 12'hA5C, 1'b0);

        r0 = 1'b1; ch0 = 3'd5; req0 = 1'b1;
        @(negedge clk);
        check("wr_gnt", gnt, 1);
        r0 = 1'b0; req0 = 1'b0;
        repeat (4) @(negedge clk);
        check("wr_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        last = 1'b1;
        idle_spur();
        check_reset_outputs("after_stray");

        txn(1'b1, 1'b1, 3'd6, 3'd2, 4, 12'h3C3, 1'b0);
        txn(1'b0, 1'b0, 3'd0, 3'd0, 1, 12'h777, 1'b1);
        txn(1'b1, 1'b0, 3'd1, 3'd0, 100, 12'hFFF, 1'b0);
        txn(1'b0, 1'b1, 3'd0, 3'd4, T - 1, 12'h001, 1'b1);
        txn(1'b1, 1'b0, 3'd7, 3'd0, T - 2, 12'h800, 1'b0);
        txn(1'b1, 1'b0, 3'd2, 3'd0, 0, 12'h123, 1'b1);

        for (int i = 0; i < 40; i++)
            txn(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                int'($urandom_range(0, T + 2)), 12'($urandom), 1'($urandom));
        while (r0 || r1)
            txn(1'b0, 1'b0, 3'd0, 3'd0, 3, 12'h0AB, 1'b0);
        idle_spur();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
